// File: rtl/decode_issue_queue.sv
// decode_issue_queue: registered RV32I decoder feeding a decoded-entry FIFO, with a load scoreboard interlock.
// Define DECODE_MEXT_EN to decode RV32M ops and hold back a second divide while one is still queued.

package rv32i_types;
    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    localparam logic [2:0] cmp_blt  = 3'b100;
    localparam logic [2:0] cmp_bltu = 3'b110;

    typedef enum logic [3:0] {
        alu_add    = 4'd0,
        alu_sll    = 4'd1,
        alu_sra    = 4'd2,
        alu_sub    = 4'd3,
        alu_xor    = 4'd4,
        alu_srl    = 4'd5,
        alu_or     = 4'd6,
        alu_and    = 4'd7,
        alu_mul    = 4'd8,
        alu_mulh   = 4'd9,
        alu_mulhsu = 4'd10,
        alu_mulhu  = 4'd11,
        alu_div    = 4'd12,
        alu_divu   = 4'd13,
        alu_rem    = 4'd14,
        alu_remu   = 4'd15
    } alu_ops;

    typedef struct packed {
        alu_ops     aluop;
        logic [2:0] cmpop;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic [2:0] regfilemux_sel;
        logic [2:0] mdrmux_sel;
        logic       load_regfile;
        logic       dmem_read;
        logic       dmem_write;
        logic       jal;
        logic       jalr;
        logic       br;
        logic       use_rs1;
        logic       use_rs2;
        logic [3:0] byte_enable;
    } rv32i_control_word;
endpackage

module decode_issue_queue
    import rv32i_types::*;
#(
    parameter int XLEN        = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int NUM_REGS    = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_instr,
    input  logic [XLEN-1:0]                in_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output rv32i_control_word              out_ctrl,
    output logic [XLEN-1:0]                out_pc,
    output logic [4:0]                     out_rd,
    output logic [4:0]                     out_rs1,
    output logic [4:0]                     out_rs2,
    input  logic                           flush,
    input  logic                           wb_clr,
    input  logic [4:0]                     wb_rd,
    output logic [$clog2(QUEUE_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    logic              mext_sel_s;
    rv32i_control_word dec_s;

    logic              hz_s;
    logic              full_s;
    logic              div_block_s;
    logic              enq_s;
    logic              deq_s;
    logic              set_sb_s;

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [QUEUE_DEPTH-1:0] vld_r;
    logic [NUM_REGS-1:0]    sb_r;
    logic [31:0]            sb_ext_s;
    logic [NUM_REGS-1:0]    sb_set_s;
    logic [NUM_REGS-1:0]    sb_clr_s;
    logic [NUM_REGS-1:0]    sb_flush_s;

    rv32i_control_word ctrl_q [QUEUE_DEPTH];
    logic [XLEN-1:0]   pc_q   [QUEUE_DEPTH];
    logic [4:0]        rd_q   [QUEUE_DEPTH];
    logic [4:0]        rs1_q  [QUEUE_DEPTH];
    logic [4:0]        rs2_q  [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] set_q;

    assign opcode_s = in_instr[6:0];
    assign funct3_s = in_instr[14:12];
    assign rd_s     = in_instr[11:7];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];

`ifdef DECODE_MEXT_EN
    logic                   is_div_s;
    logic [QUEUE_DEPTH-1:0] div_q;

    assign mext_sel_s  = (opcode_s == op_reg) && (in_instr[31:25] == 7'b0000001);
    assign is_div_s    = mext_sel_s & funct3_s[2];
    // Only one divide may sit in the queue at a time; MUL ops are not held back.
    assign div_block_s = (|(vld_r & div_q)) & is_div_s;
`else
    logic unused_funct7_s;

    assign mext_sel_s      = 1'b0;
    assign div_block_s     = 1'b0;
    assign unused_funct7_s = ^{in_instr[31], in_instr[29:25]};
`endif

    // Combinational decode of the presented instruction into a control word
    always_comb begin
        dec_s = '0;
        case (opcode_s)
            op_lui: begin
                dec_s.load_regfile   = 1'b1;
                dec_s.regfilemux_sel = 3'd2;
            end
            op_auipc: begin
                dec_s.alumux1_sel  = 1'b1;
                dec_s.alumux2_sel  = 3'd1;
                dec_s.aluop        = alu_add;
                dec_s.load_regfile = 1'b1;
            end
            op_jal: begin
                dec_s.alumux2_sel    = 3'd4;
                dec_s.jal            = 1'b1;
                dec_s.regfilemux_sel = 3'd4;
                dec_s.load_regfile   = 1'b1;
            end
            op_jalr: begin
                dec_s.jalr           = 1'b1;
                dec_s.regfilemux_sel = 3'd4;
                dec_s.use_rs1        = 1'b1;
                dec_s.load_regfile   = 1'b1;
            end
            op_br: begin
                dec_s.alumux1_sel = 1'b1;
                dec_s.alumux2_sel = 3'd2;
                dec_s.br          = 1'b1;
                dec_s.cmpop       = funct3_s;
                dec_s.use_rs1     = 1'b1;
                dec_s.use_rs2     = 1'b1;
            end
            op_load: begin
                dec_s.dmem_read      = 1'b1;
                dec_s.mdrmux_sel     = funct3_s;
                dec_s.regfilemux_sel = 3'd3;
                dec_s.load_regfile   = 1'b1;
                dec_s.use_rs1        = 1'b1;
            end
            op_store: begin
                dec_s.dmem_write  = 1'b1;
                dec_s.alumux2_sel = 3'd3;
                dec_s.use_rs1     = 1'b1;
                dec_s.use_rs2     = 1'b1;
                case (funct3_s[1:0])
                    2'b00:   dec_s.byte_enable = 4'b0001;
                    2'b01:   dec_s.byte_enable = 4'b0011;
                    2'b10:   dec_s.byte_enable = 4'b1111;
                    default: dec_s.byte_enable = 4'b0000;
                endcase
            end
            op_imm, op_reg: begin
                dec_s.load_regfile = 1'b1;
                dec_s.use_rs1      = 1'b1;
                if (opcode_s == op_reg) begin
                    dec_s.alumux2_sel = 3'd5;
                    dec_s.use_rs2     = 1'b1;
                end else begin
                    dec_s.alumux2_sel = 3'd0;
                end
                if (mext_sel_s) begin
                    dec_s.aluop = alu_ops'({1'b1, funct3_s});
                end else begin
                    case (funct3_s)
                        3'b000: dec_s.aluop = ((opcode_s == op_reg) && in_instr[30]) ? alu_sub : alu_add;
                        3'b010: begin
                            dec_s.cmpop          = cmp_blt;
                            dec_s.regfilemux_sel = 3'd1;
                        end
                        3'b011: begin
                            dec_s.cmpop          = cmp_bltu;
                            dec_s.regfilemux_sel = 3'd1;
                        end
                        3'b101:  dec_s.aluop = in_instr[30] ? alu_sra : alu_srl;
                        default: dec_s.aluop = alu_ops'({1'b0, funct3_s});
                    endcase
                end
            end
            default: dec_s = '0;
        endcase
    end

    for (genvar i = 0; i < 32; i++) begin : g_sb_ext
        if (i < NUM_REGS) begin : g_tracked
            assign sb_ext_s[i] = sb_r[i];
        end else begin : g_untracked
            assign sb_ext_s[i] = 1'b0;
        end
    end

    assign hz_s = (dec_s.use_rs1 & sb_ext_s[rs1_s])
                | (dec_s.use_rs2 & sb_ext_s[rs2_s])
                | (dec_s.load_regfile & (rd_s != 5'd0) & sb_ext_s[rd_s]);

    // Space freed by a same-cycle dequeue is deliberately not reused until the next cycle.
    assign full_s    = (count == CNT_W'(QUEUE_DEPTH));
    assign in_ready  = ~full_s & ~hz_s & ~flush & ~div_block_s;
    assign out_valid = (count != CNT_W'(0));
    assign enq_s     = in_valid & in_ready;
    assign deq_s     = out_valid & out_ready & ~flush;
    assign set_sb_s  = enq_s & dec_s.dmem_read & (rd_s != 5'd0);

    // Scoreboard set/clear/flush masks applied at the next edge
    always_comb begin
        sb_set_s   = '0;
        sb_clr_s   = '0;
        sb_flush_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_set_s[i] = set_sb_s && (rd_s == 5'(i));
            sb_clr_s[i] = wb_clr && (wb_rd != 5'd0) && (wb_rd == 5'(i));
            for (int j = 0; j < QUEUE_DEPTH; j++) begin
                sb_flush_s[i] = sb_flush_s[i] | (flush & vld_r[j] & set_q[j] & (rd_q[j] == 5'(i)));
            end
        end
    end

    // Pointers, occupancy, slot valid flags and the load scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
            vld_r    <= '0;
            sb_r     <= '0;
        end else begin
            sb_r <= (sb_r & ~sb_clr_s & ~sb_flush_s) | sb_set_s;
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count    <= '0;
                vld_r    <= '0;
            end else begin
                if (enq_s) begin
                    wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
                    vld_r[wr_ptr_r] <= 1'b1;
                end
                if (deq_s) begin
                    rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
                    vld_r[rd_ptr_r] <= 1'b0;
                end
                case ({enq_s, deq_s})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage written at the tail on enqueue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                ctrl_q[i] <= '0;
                pc_q[i]   <= '0;
                rd_q[i]   <= '0;
                rs1_q[i]  <= '0;
                rs2_q[i]  <= '0;
            end
        end else if (enq_s) begin
            ctrl_q[wr_ptr_r] <= dec_s;
            pc_q[wr_ptr_r]   <= in_pc;
            rd_q[wr_ptr_r]   <= rd_s;
            rs1_q[wr_ptr_r]  <= rs1_s;
            rs2_q[wr_ptr_r]  <= rs2_s;
            set_q[wr_ptr_r]  <= set_sb_s;
        end
    end

`ifdef DECODE_MEXT_EN
    // Divide marker per slot, only meaningful while the slot's valid flag is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (enq_s) begin
            div_q[wr_ptr_r] <= is_div_s;
        end
    end
`endif

    // Head entry presented to execute, zeroed while the queue is empty
    always_comb begin
        if (out_valid) begin
            out_ctrl = ctrl_q[rd_ptr_r];
            out_pc   = pc_q[rd_ptr_r];
            out_rd   = rd_q[rd_ptr_r];
            out_rs1  = rs1_q[rd_ptr_r];
            out_rs2  = rs2_q[rd_ptr_r];
        end else begin
            out_ctrl = '0;
            out_pc   = '0;
            out_rd   = 5'd0;
            out_rs1  = 5'd0;
            out_rs2  = 5'd0;
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: expected head entries are queued at enqueue and compared at dequeue.
module tb_decode_issue_queue;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;
    logic              out_valid;
    logic              out_ready;
    rv32i_control_word out_ctrl;
    logic [31:0]       out_pc;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic              flush;
    logic              wb_clr;
    logic [4:0]        wb_rd;
    logic [2:0]        count;

    typedef struct {
        rv32i_control_word ctrl;
        logic [31:0]       pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    decode_issue_queue #(.XLEN(32), .QUEUE_DEPTH(4), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .flush(flush), .wb_clr(wb_clr), .wb_rd(wb_rd), .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rv32i_control_word cw(input alu_ops op, input logic [2:0] m2,
                                             input logic [2:0] rfm, input logic lr,
                                             input logic r1, input logic r2);
        rv32i_control_word c;
        c = '0;
        c.aluop          = op;
        c.alumux2_sel    = m2;
        c.regfilemux_sel = rfm;
        c.load_regfile   = lr;
        c.use_rs1        = r1;
        c.use_rs2        = r2;
        return c;
    endfunction

    function automatic rv32i_control_word c_lw();
        rv32i_control_word c;
        c = cw(alu_add, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0);
        c.dmem_read  = 1'b1;
        c.mdrmux_sel = 3'b010;
        return c;
    endfunction

    function automatic rv32i_control_word c_sw();
        rv32i_control_word c;
        c = cw(alu_add, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1);
        c.dmem_write  = 1'b1;
        c.byte_enable = 4'b1111;
        return c;
    endfunction

    function automatic rv32i_control_word c_sltu();
        rv32i_control_word c;
        c = cw(alu_add, 3'd5, 3'd1, 1'b1, 1'b1, 1'b1);
        c.cmpop = 3'b110;
        return c;
    endfunction

    // One clock: retire/record handshakes seen at the falling edge, then advance past the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("deq_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("head_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    chk("head_pc",   64'(out_pc),   64'(e.pc));
                    chk("head_rd",   64'(out_rd),   64'(e.rd));
                    chk("head_rs1",  64'(out_rs1),  64'(e.rs1));
                    chk("head_rs2",  64'(out_rs2),  64'(e.rs2));
                end
            end
            if (in_valid && in_ready) sbq.push_back(pend);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input rv32i_control_word c);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        pend.ctrl = c;
        pend.pc   = pc;
        pend.rd   = instr[11:7];
        pend.rs1  = instr[19:15];
        pend.rs2  = instr[24:20];
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rv32i_control_word c_mul;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        out_ready = 1'b0; flush = 1'b0; wb_clr = 1'b0; wb_rd = 5'd0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);

        // ADDI x1,x0,5 then SUB x13,x1,x2
        out_ready = 1'b1;
        drive(32'h00500093, 32'h100, cw(alu_add, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0));
        cyc();
        chk("addi_count1", 64'(count), 64'd1);
        chk("addi_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        cyc();
        chk("addi_count0", 64'(count), 64'd0);
        chk("addi_drained", 64'(out_valid), 64'd0);
        drive(32'h402086B3, 32'h104, cw(alu_sub, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1));
        cyc();
        in_valid = 1'b0;
        cyc();

        // LW x5 then ADD x6,x5,x5 blocked until wb_clr of x5
        drive(32'h00012283, 32'h108, c_lw());
        cyc();
        drive(32'h00528333, 32'h10C, cw(alu_add, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1));
        chk("raw_block", 64'(in_ready), 64'd0);
        cyc(); cyc();
        chk("raw_block_hold", 64'(in_ready), 64'd0);
        wb_clr = 1'b1; wb_rd = 5'd6;
        cyc();
        chk("wb_other_reg_block", 64'(in_ready), 64'd0);
        wb_rd = 5'd5;
        cyc();
        wb_clr = 1'b0; #1;
        chk("raw_release", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        cyc();

        // Fill to depth with out_ready low; fifth waits, then order preserved across wrap
        out_ready = 1'b0;
        drive(32'h4030D613, 32'h200, cw(alu_sra, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0)); cyc();
        drive(32'h00112223, 32'h204, c_sw()); cyc();
        drive(32'h12345437, 32'h208, cw(alu_add, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0)); cyc();
        drive(32'h0000007F, 32'h20C, '0); cyc();
        chk("full_count", 64'(count), 64'd4);
        drive(32'h0020B5B3, 32'h210, c_sltu());
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cyc();
        chk("full_hold_count", 64'(count), 64'd4);
        out_ready = 1'b1; #1;
        chk("deq_no_same_cycle_space", 64'(in_ready), 64'd0);
        cyc();
        out_ready = 1'b0; #1;
        chk("after_deq_count", 64'(count), 64'd3);
        chk("after_deq_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("refill_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("wrap_drained", 64'(count), 64'd0);

        // Flush with LW x7 queued clears its scoreboard bit
        out_ready = 1'b0;
        drive(32'h00012383, 32'h300, c_lw()); cyc();
        drive(32'h00500093, 32'h304, cw(alu_add, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0)); cyc();
        chk("pre_flush_count", 64'(count), 64'd2);
        drive(32'h00738433, 32'h308, cw(alu_add, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1));
        chk("sb7_block", 64'(in_ready), 64'd0);
        flush = 1'b1; out_ready = 1'b1; #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        cyc();
        flush = 1'b0; out_ready = 1'b0; #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_sb7_cleared", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();

        // Same-cycle set and clear of x3: set wins; wb_rd=0 is ignored
        drive(32'h00012183, 32'h400, c_lw());
        wb_clr = 1'b1; wb_rd = 5'd3;
        cyc();
        wb_clr = 1'b0;
        drive(32'h000184B3, 32'h404, cw(alu_add, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1));
        chk("set_wins", 64'(in_ready), 64'd0);
        wb_clr = 1'b1; wb_rd = 5'd0;
        cyc();
        chk("wb_x0_ignored", 64'(in_ready), 64'd0);
        wb_rd = 5'd3;
        cyc();
        wb_clr = 1'b0; #1;
        chk("sb3_cleared", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        cyc();

        // MUL x1,x2,x3
`ifdef DECODE_MEXT_EN
        c_mul = cw(alu_mul, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1);
`else
        c_mul = cw(alu_add, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1);
`endif
        drive(32'h023100B3, 32'h500, c_mul);
        cyc();
        in_valid = 1'b0;
        cyc();
`ifdef DECODE_MEXT_EN
        out_ready = 1'b0;
        drive(32'h023140B3, 32'h504, cw(alu_div, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1)); cyc();
        drive(32'h023100B3, 32'h508, c_mul);
        chk("mul_not_div_blocked", 64'(in_ready), 64'd1);
        cyc();
        drive(32'h023140B3, 32'h50C, cw(alu_div, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1));
        chk("div_busy_block", 64'(in_ready), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
`endif

        // Reset mid-operation with LW x4 queued
        out_ready = 1'b0;
        drive(32'h00012203, 32'h600, c_lw());
        cyc();
        in_valid = 1'b0;
        #2 rst_n = 1'b0; #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        sbq.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(32'h00420333, 32'h604, cw(alu_add, 3'd5, 3'd0, 1'b1, 1'b1, 1'b1));
        chk("midrst_sb_cleared", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
